// File: rtl/muldiv_unit_if.sv
// Handshake/bus bundle for muldiv_unit: operation start, MTHI/MTLO writes, HI/LO results.
// MULDIV_DIVZERO_FLAG_EN adds the div_zero result flag.
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             op_div;
  logic             Signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
`ifdef MULDIV_DIVZERO_FLAG_EN
  logic             div_zero;
`endif

  modport master (
    output start, op_div, Signed, a, b, hi_we, lo_we, wdata,
`ifdef MULDIV_DIVZERO_FLAG_EN
    input  div_zero,
`endif
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op_div, Signed, a, b, hi_we, lo_we, wdata,
`ifdef MULDIV_DIVZERO_FLAG_EN
    output div_zero,
`endif
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers (one bit per cycle, WIDTH+1 cycles).
// MULDIV_DIVZERO_FLAG_EN: div_zero output and early finish for divide by zero.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic         clk,
  input logic         reset,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic               div_q, div_d;
  logic               neg_a_q, neg_a_d;
  logic               neg_b_q, neg_b_d;
  logic               bzero_q, bzero_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               in_neg_a, in_neg_b;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH:0]   div_shift;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] prod, prod_neg;

  assign in_neg_a  = bus.Signed & bus.a[WIDTH-1];
  assign in_neg_b  = bus.Signed & bus.b[WIDTH-1];
  assign abs_a     = in_neg_a ? -bus.a : bus.a;
  assign abs_b     = in_neg_b ? -bus.b : bus.b;

  // acc = {upper W+1 bits, lower W bits}; multiply shifts right, divide shifts left
  assign mul_sum   = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign div_shift = {acc_q[2*WIDTH-1:0], 1'b0};
  assign div_trial = div_shift[2*WIDTH:WIDTH] - {1'b0, opb_q};
  assign prod      = acc_q[2*WIDTH-1:0];
  assign prod_neg  = -prod;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    a_d     = a_q;
    div_d   = div_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    bzero_d = bzero_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          acc_d   = {{(WIDTH+1){1'b0}}, abs_a};
          opb_d   = abs_b;
          a_d     = bus.a;
          div_d   = bus.op_div;
          neg_a_d = in_neg_a;
          neg_b_d = in_neg_b;
          bzero_d = (bus.b == '0);
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = StCalc;
`ifdef MULDIV_DIVZERO_FLAG_EN
          if (bus.op_div && (bus.b == '0)) state_d = StFix;
`endif
        end else begin
          if (bus.hi_we) hi_d = bus.wdata;
          if (bus.lo_we) lo_d = bus.wdata;
        end
      end
      StCalc: begin
        if (div_q) begin
          // restoring step: keep the subtraction only if it did not go negative
          if (!div_trial[WIDTH]) acc_d = {div_trial, div_shift[WIDTH-1:1], 1'b1};
          else                   acc_d = div_shift;
        end else begin
          acc_d = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = StFix;
      end
      StFix: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = StIdle;
        if (div_q && bzero_q) begin
          hi_d = a_q;
          lo_d = '1;
          dz_d = 1'b1;
        end else if (div_q) begin
          hi_d = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
          lo_d = (neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        end else begin
          {hi_d, lo_d} = (neg_a_q ^ neg_b_q) ? prod_neg : prod;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      a_q     <= '0;
      div_q   <= 1'b0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      bzero_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      a_q     <= a_d;
      div_q   <= div_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      bzero_q <= bzero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
`ifdef MULDIV_DIVZERO_FLAG_EN
  assign bus.div_zero = dz_q;
`else
  logic unused_dz;
  assign unused_dz = dz_q;
`endif

endmodule
